// File: rtl/title_sprite_sequencer.sv
// Title-screen sprite sequencer: a registered 2-stage raster-to-sheet address pipeline and a
// per-frame FSM for slide-in, Press Start blink, exit flash and done. Optional slide-in: TITLE_SLIDE_EN.
module title_sprite_sequencer #(
    parameter int SHEET_W      = 435,
    parameter int ADDR_W       = 17,
    parameter int BLINK_FRAMES = 30,
    parameter int EXIT_FRAMES  = 60,
    parameter int SLIDE_START  = 160,
    parameter int SLIDE_STEP   = 4
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic [9:0]        DrawX,
    input  logic [9:0]        DrawY,
    input  logic              frame_tick,
    input  logic              start_key,
    output logic [ADDR_W-1:0] title_address,
    output logic              is_title,
    output logic [2:0]        region_id,
    output logic              title_done
);

    localparam int CNT_MAX = (BLINK_FRAMES > EXIT_FRAMES) ? BLINK_FRAMES : EXIT_FRAMES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int SLIDE_W = $clog2(SLIDE_START + 1);

    localparam logic [CNT_W-1:0] BLINK_LAST = CNT_W'(BLINK_FRAMES - 1);
    localparam logic [CNT_W-1:0] EXIT_LAST  = CNT_W'(EXIT_FRAMES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

`ifdef TITLE_SLIDE_EN
    typedef enum logic [1:0] {INTRO = 2'd0, SHOW = 2'd1, EXIT = 2'd2, DONE = 2'd3} state_t;
    localparam state_t RESET_STATE = INTRO;
    localparam logic [SLIDE_W-1:0] STEP = SLIDE_W'(SLIDE_STEP);
`else
    typedef enum logic [1:0] {SHOW = 2'd1, EXIT = 2'd2, DONE = 2'd3} state_t;
    localparam state_t RESET_STATE = SHOW;
`endif

    state_t             state, state_n;
    logic [CNT_W-1:0]   cnt, cnt_n;
    logic               phase, phase_n;   // 1 = Press Start visible
    logic               done_n;
    logic [SLIDE_W-1:0] slide_off;
    logic               press_vis;

    // ---------------- frame sequencer ----------------
`ifdef TITLE_SLIDE_EN
    logic [SLIDE_W-1:0] slide_n;
    always_ff @(posedge Clk) begin
        if (!Reset_n) slide_off <= SLIDE_W'(SLIDE_START);
        else          slide_off <= slide_n;
    end
    assign press_vis = phase && (state != INTRO);
`else
    assign slide_off = '0;
    assign press_vis = phase;
`endif

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            state      <= RESET_STATE;
            cnt        <= '0;
            phase      <= 1'b1;
            title_done <= 1'b0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            phase      <= phase_n;
            title_done <= done_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        phase_n = phase;
        done_n  = 1'b0;
`ifdef TITLE_SLIDE_EN
        slide_n = slide_off;
`endif
        if (frame_tick) begin
            case (state)
`ifdef TITLE_SLIDE_EN
                INTRO: begin
                    if (slide_off <= STEP) begin
                        slide_n = '0;
                        state_n = SHOW;
                    end else begin
                        slide_n = slide_off - STEP;
                    end
                end
`endif
                SHOW: begin
                    // a start press wins over a blink wrap on the same tick
                    if (start_key) begin
                        state_n = EXIT;
                        cnt_n   = '0;
                        phase_n = 1'b1;
                    end else if (cnt == BLINK_LAST) begin
                        cnt_n   = '0;
                        phase_n = ~phase;
                    end else begin
                        cnt_n = cnt + CNT_ONE;
                    end
                end
                EXIT: begin
                    if (cnt == EXIT_LAST) begin
                        done_n  = 1'b1;
                        state_n = DONE;
                        cnt_n   = '0;
                        phase_n = 1'b1;
                    end else begin
                        cnt_n = cnt + CNT_ONE;
                        if (cnt[1:0] == 2'd3) phase_n = ~phase;
                    end
                end
                default: ;
            endcase
        end
    end

    // ---------------- stage 1: region decode ----------------
    function automatic logic in_rect(input logic [9:0] x, input logic [9:0] y,
                                     input logic [9:0] x0, input logic [9:0] x1,
                                     input logic [9:0] y0, input logic [9:0] y1);
        return (x >= x0) && (x < x1) && (y >= y0) && (y < y1);
    endfunction

    logic [9:0] ty0, ty1;
    logic       hit;
    logic [2:0] id;
    logic [9:0] lx, ly;

    assign ty0 = 10'd150 + 10'(slide_off);
    assign ty1 = 10'd306 + 10'(slide_off);

    always_comb begin
        hit = 1'b0;
        id  = 3'd0;
        lx  = '0;
        ly  = '0;
        if (in_rect(DrawX, DrawY, 10'd186, 10'd456, ty0, ty1)) begin
            hit = 1'b1; id = 3'd1; lx = DrawX - 10'd186; ly = DrawY - ty0;
        end else if (in_rect(DrawX, DrawY, 10'd273, 10'd366, 10'd440, 10'd466)) begin
            hit = 1'b1; id = 3'd2; lx = DrawX - 10'd273; ly = DrawY - 10'd440;
        end else if (in_rect(DrawX, DrawY, 10'd271, 10'd369, 10'd316, 10'd336)) begin
            // hidden Press Start masks the pixel; nothing below shows through
            if (press_vis) begin
                hit = 1'b1; id = 3'd3; lx = DrawX - 10'd271; ly = DrawY - 10'd316;
            end
        end else if (in_rect(DrawX, DrawY, 10'd85, 10'd180, 10'd5, 10'd73)) begin
            hit = 1'b1; id = 3'd4; lx = DrawX - 10'd85; ly = DrawY - 10'd5;
        end else if (in_rect(DrawX, DrawY, 10'd476, 10'd544, 10'd19, 10'd73)) begin
            hit = 1'b1; id = 3'd5; lx = DrawX - 10'd476; ly = DrawY - 10'd19;
        end
    end

    logic       s1_hit;
    logic [2:0] s1_id;
    logic [9:0] s1_lx, s1_ly;

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            s1_hit <= 1'b0;
            s1_id  <= 3'd0;
            s1_lx  <= '0;
            s1_ly  <= '0;
        end else begin
            s1_hit <= hit;
            s1_id  <= id;
            s1_lx  <= lx;
            s1_ly  <= ly;
        end
    end

    // ---------------- stage 2: sheet address ----------------
    logic [9:0]  sx, sy;
    logic [31:0] addr_full;

    always_comb begin
        sx = '0;
        sy = '0;
        case (s1_id)
            3'd2:    begin sx = 10'd269; sy = 10'd0;  end
            3'd3:    begin sx = 10'd269; sy = 10'd26; end
            3'd4:    begin sx = 10'd269; sy = 10'd46; end
            3'd5:    begin sx = 10'd368; sy = 10'd0;  end
            default: begin sx = 10'd0;   sy = 10'd0;  end
        endcase
        addr_full = 32'(sx) + 32'(s1_lx) + (32'(sy) + 32'(s1_ly)) * 32'(SHEET_W);
    end

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            title_address <= '0;
            is_title      <= 1'b0;
            region_id     <= 3'd0;
        end else begin
            title_address <= s1_hit ? addr_full[ADDR_W-1:0] : '0;
            is_title      <= s1_hit;
            region_id     <= s1_hit ? s1_id : 3'd0;
        end
    end

endmodule

// File: tb/tb_title_sprite_sequencer.sv
// Directed bench for title_sprite_sequencer: pipeline latency, region addresses, blink,
// exit/done pulse and mid-exit reset. Slide-in checks run only when TITLE_SLIDE_EN is defined.
module tb_title_sprite_sequencer;

    logic        Clk = 1'b0;
    logic        Reset_n;
    logic [9:0]  DrawX, DrawY;
    logic        frame_tick, start_key;
    logic [16:0] title_address;
    logic        is_title;
    logic [2:0]  region_id;
    logic        title_done;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;

`ifdef TITLE_SLIDE_EN
    localparam logic [9:0] TY0 = 10'd310;
`else
    localparam logic [9:0] TY0 = 10'd150;
`endif

    always #5 Clk = ~Clk;

    title_sprite_sequencer dut (
        .Clk           (Clk),
        .Reset_n       (Reset_n),
        .DrawX         (DrawX),
        .DrawY         (DrawY),
        .frame_tick    (frame_tick),
        .start_key     (start_key),
        .title_address (title_address),
        .is_title      (is_title),
        .region_id     (region_id),
        .title_done    (title_done)
    );

    always @(negedge Clk) if (Reset_n && title_done) done_cnt++;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d exp %0d", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge Clk);
            #1;
        end
    endtask

    task automatic ticks(input int n, input logic key);
        repeat (n) begin
            frame_tick = 1'b1;
            start_key  = key;
            step(1);
            frame_tick = 1'b0;
        end
    endtask

    task automatic pix(input string tag, input logic [9:0] x, input logic [9:0] y,
                       input logic [31:0] addr, input logic hit, input logic [2:0] id);
        DrawX = x;
        DrawY = y;
        step(2);
        chk({tag, "_addr"}, 32'(title_address), addr);
        chk({tag, "_hit"},  32'(is_title), 32'(hit));
        chk({tag, "_id"},   32'(region_id), 32'(id));
    endtask

    initial begin
        Reset_n    = 1'b0;
        frame_tick = 1'b0;
        start_key  = 1'b0;
        DrawX      = 10'd186;
        DrawY      = TY0;
        step(3);
        chk("rst_addr", 32'(title_address), 0);
        chk("rst_hit",  32'(is_title), 0);
        chk("rst_id",   32'(region_id), 0);
        chk("rst_done", 32'(title_done), 0);
        Reset_n = 1'b1;

`ifdef TITLE_SLIDE_EN
        pix("intro_top", 10'd186, 10'd310, 0, 1'b1, 3'd1);
        pix("intro_old", 10'd186, 10'd150, 0, 1'b0, 3'd0);
        ticks(39, 1'b1);
        pix("intro_39", 10'd186, 10'd150, 0, 1'b0, 3'd0);
        ticks(1, 1'b1);
        start_key = 1'b0;
`endif

        // exact two-cycle latency
        DrawX = 10'd0; DrawY = 10'd0;
        step(2);
        DrawX = 10'd186; DrawY = 10'd150;
        step(1);
        chk("lat1_hit", 32'(is_title), 0);
        step(1);
        chk("lat2_hit", 32'(is_title), 1);
        chk("lat2_id",  32'(region_id), 1);
        chk("lat2_addr", 32'(title_address), 0);

        pix("title_br",   10'd455, 10'd305, 67694, 1'b1, 3'd1);
        pix("title_xout", 10'd456, 10'd305, 0,     1'b0, 3'd0);
        pix("title_yout", 10'd455, 10'd306, 0,     1'b0, 3'd0);
        pix("ctrl",       10'd273, 10'd440, 269,   1'b1, 3'd2);
        pix("sushi",      10'd85,  10'd5,   20279, 1'b1, 3'd4);
        pix("fish",       10'd476, 10'd19,  368,   1'b1, 3'd5);
        pix("fish_br",    10'd543, 10'd72,  23490, 1'b1, 3'd5);
        pix("none",       10'd0,   10'd0,   0,     1'b0, 3'd0);
        pix("press_0",    10'd271, 10'd316, 11579, 1'b1, 3'd3);

        // blink: visible 0-29, hidden 30-59, visible at 60
        ticks(29, 1'b0);
        pix("press_29", 10'd271, 10'd316, 11579, 1'b1, 3'd3);
        ticks(1, 1'b0);
        pix("press_30", 10'd271, 10'd316, 0, 1'b0, 3'd0);
        ticks(29, 1'b0);
        pix("press_59", 10'd271, 10'd316, 0, 1'b0, 3'd0);
        ticks(1, 1'b0);
        pix("press_60", 10'd271, 10'd316, 11579, 1'b1, 3'd3);
        ticks(30, 1'b0);
        pix("press_90", 10'd368, 10'd335, 0, 1'b0, 3'd0);

        // exit, with start_key held the whole time
        ticks(1, 1'b1);
        pix("exit_0", 10'd271, 10'd316, 11579, 1'b1, 3'd3);
        ticks(3, 1'b1);
        pix("exit_3", 10'd271, 10'd316, 11579, 1'b1, 3'd3);
        ticks(1, 1'b1);
        pix("exit_4", 10'd271, 10'd316, 0, 1'b0, 3'd0);
        ticks(55, 1'b1);
        chk("done_early", 32'(done_cnt), 0);
        chk("done_lvl59", 32'(title_done), 0);
        ticks(1, 1'b1);
        chk("done_pulse", 32'(title_done), 1);
        step(1);
        chk("done_drop", 32'(title_done), 0);
        ticks(5, 1'b1);
        chk("done_once", 32'(done_cnt), 1);
        pix("done_press", 10'd271, 10'd316, 11579, 1'b1, 3'd3);
        pix("done_title", 10'd186, 10'd150, 0, 1'b1, 3'd1);
        start_key = 1'b0;

        // reset in the middle of EXIT
        Reset_n = 1'b0;
        step(1);
        Reset_n = 1'b1;
`ifdef TITLE_SLIDE_EN
        ticks(40, 1'b0);
`endif
        ticks(1, 1'b1);
        ticks(10, 1'b0);
        pix("mid_exit", 10'd186, 10'd150, 0, 1'b1, 3'd1);
        Reset_n = 1'b0;
        step(1);
        chk("mrst_addr", 32'(title_address), 0);
        chk("mrst_hit",  32'(is_title), 0);
        chk("mrst_id",   32'(region_id), 0);
        DrawX = 10'd186; DrawY = TY0;
        Reset_n = 1'b1;
        step(1);
        chk("flush_hit", 32'(is_title), 0);
        step(1);
        chk("post_hit",  32'(is_title), 1);
        chk("post_addr", 32'(title_address), 0);
`ifdef TITLE_SLIDE_EN
        ticks(40, 1'b0);
`endif
        ticks(4, 1'b0);
        pix("post_press", 10'd271, 10'd316, 11579, 1'b1, 3'd3);
        ticks(56, 1'b0);
        chk("post_nodone", 32'(done_cnt), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
